// File: rtl/ram_arbiter_2port_if.sv
// ram_arbiter_2port_if: requester, RAM and status signals of the two-port RAM arbiter
interface ram_arbiter_2port_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/ram_arbiter_2port.sv
// ram_arbiter_2port: round-robin arbiter and sequencer sharing one synchronous RAM between two requesters
module ram_arbiter_2port #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  ram_arbiter_2port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t            state_q, state_d;
  logic              last_q, last_d, sel_q, sel_d, rd_q, rd_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              el0, el1, win;
  // a port in its own ack cycle is masked so a held req is not re-granted at once
  assign el0 = bus.req0 & ~ack0_q;
  assign el1 = bus.req1 & ~ack1_q;
  assign win = (el0 & el1) ? ~last_q : el1;
  // next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    rd_d        = rd_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: if (el0 | el1) begin
        state_d     = ISSUE;
        mem_en_d    = 1'b1;
        sel_d       = win;
        last_d      = win;
        mem_we_d    = win ? bus.we1 : bus.we0;
        rd_d        = ~(win ? bus.we1 : bus.we0);
        mem_addr_d  = win ? bus.addr1 : bus.addr0;
        mem_wdata_d = win ? bus.wdata1 : bus.wdata0;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d  = IDLE;
        ack0_d   = ~sel_q;
        ack1_d   = sel_q;
        rdata0_d = (rd_q & ~sel_q) ? bus.mem_rdata : rdata0_q;
        rdata1_d = (rd_q & sel_q) ? bus.mem_rdata : rdata1_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; last_grant resets to 1 so the first tie goes to port 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      rd_q        <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      rd_q        <= rd_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_ram_arbiter_2port.sv
// tb_ram_arbiter_2port: randomized and directed check of the arbiter against a transaction-level model
module tb_ram_arbiter_2port;
  typedef struct {logic we; logic [7:0] addr; logic [7:0] wdata;} cmd_t;
  logic clk = 1'b0, rst = 1'b1, fill = 1'b1;
  always #5 clk = ~clk;
  ram_arbiter_2port_if #(.ADDR_W(8), .DATA_W(8)) bus();
  ram_arbiter_2port #(.ADDR_W(8), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 11);
    else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= ram[bus.mem_addr];
    end
  end
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [7:0] ref_mem [256];
  cmd_t q [2][$];
  cmd_t cur [2];
  logic rq [2];
  int idle_at = 0, gnt_c = -10, last = 1;
  int ack_at [2];
  logic pend_rd [2];
  logic [7:0] pend_val [2], exp_rd [2];
  logic g_we;
  logic [7:0] g_addr, g_wdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic step(input logic r);
    int w;
    logic e0, e1;
    for (int i = 0; i < 2; i++) if (ack_at[i] == cyc && pend_rd[i]) exp_rd[i] = pend_val[i];
    chk("busy", 32'(bus.busy), 32'(cyc < idle_at));
    chk("mem_en", 32'(bus.mem_en), 32'(cyc == gnt_c + 1));
    chk("mem_we", 32'(bus.mem_we), 32'(cyc == gnt_c + 1 && g_we));
    if (cyc == gnt_c + 1) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(g_addr));
      if (g_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(g_wdata));
    end
    chk("ack0", 32'(bus.ack0), 32'(ack_at[0] == cyc));
    chk("ack1", 32'(bus.ack1), 32'(ack_at[1] == cyc));
    chk("rdata0", 32'(bus.rdata0), 32'(exp_rd[0]));
    chk("rdata1", 32'(bus.rdata1), 32'(exp_rd[1]));
    for (int i = 0; i < 2; i++) begin
      if (ack_at[i] == cyc) begin
        void'(q[i].pop_front());
        rq[i] = 1'b0;
      end
      if (!rq[i] && q[i].size() > 0) begin
        cur[i] = q[i][0];
        rq[i] = 1'b1;
      end
    end
    bus.req0 = rq[0]; bus.we0 = cur[0].we; bus.addr0 = cur[0].addr; bus.wdata0 = cur[0].wdata;
    bus.req1 = rq[1]; bus.we1 = cur[1].we; bus.addr1 = cur[1].addr; bus.wdata1 = cur[1].wdata;
    rst = r;
    if (r) begin
      idle_at = 0; gnt_c = -10; last = 1;
      for (int i = 0; i < 2; i++) begin ack_at[i] = -1; exp_rd[i] = 8'h00; end
    end else if (cyc >= idle_at) begin
      e0 = rq[0] && ack_at[0] != cyc;
      e1 = rq[1] && ack_at[1] != cyc;
      if (e0 || e1) begin
        w = (e0 && e1) ? 1 - last : (e1 ? 1 : 0);
        last = w; gnt_c = cyc; idle_at = cyc + 3; ack_at[w] = cyc + 3;
        g_we = cur[w].we; g_addr = cur[w].addr; g_wdata = cur[w].wdata;
        pend_rd[w] = !g_we;
        if (g_we) ref_mem[g_addr] = g_wdata;
        else pend_val[w] = ref_mem[g_addr];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic run_idle();
    int k;
    for (k = 0; k < 300 && !(q[0].size() == 0 && q[1].size() == 0 && cyc >= idle_at); k++) step(1'b0);
    chk("drain_timeout", 32'(k < 300), 32'd1);
  endtask
  task automatic push(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d;
    q[p].push_back(c);
  endtask
  initial begin
    int k;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    for (int i = 0; i < 2; i++) begin
      ack_at[i] = -1; rq[i] = 1'b0; pend_rd[i] = 1'b0; exp_rd[i] = 8'h00;
      cur[i].we = 1'b0; cur[i].addr = 8'h00; cur[i].wdata = 8'h00;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    @(posedge clk);
    #1;
    fill = 1'b0;
    push(0, 1'b0, 8'h33, 8'h00);
    push(1, 1'b0, 8'h44, 8'h00);
    step(1'b1);
    step(1'b1);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    run_idle();
    step(1'b1);
    step(1'b1);
    push(0, 1'b1, 8'h10, 8'hA5);
    run_idle();
    push(0, 1'b0, 8'h10, 8'h00);
    run_idle();
    chk("rd_a5", 32'(bus.rdata0), 32'h A5);
    chk("rdata1_untouched", 32'(bus.rdata1), 32'h00);
    push(0, 1'b1, 8'h20, 8'h11);
    push(1, 1'b1, 8'h21, 8'h22);
    run_idle();
    push(0, 1'b0, 8'h20, 8'h00);
    push(1, 1'b0, 8'h21, 8'h00);
    run_idle();
    chk("rd_11", 32'(bus.rdata0), 32'h11);
    chk("rd_22", 32'(bus.rdata1), 32'h22);
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 8'(i), 8'h00);
      push(1, 1'b0, 8'(i + 100), 8'h00);
    end
    run_idle();
    push(0, 1'b1, 8'h50, 8'h5C);
    push(0, 1'b1, 8'h51, 8'h5D);
    run_idle();
    push(1, 1'b0, 8'h20, 8'h00);
    for (k = 0; k < 20 && cyc != gnt_c + 2; k++) step(1'b0);
    chk("reach_wait", 32'(cyc == gnt_c + 2), 32'd1);
    step(1'b1);
    chk("mid_rst_ack1", 32'(bus.ack1), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("mid_rst_rdata1", 32'(bus.rdata1), 32'h00);
    run_idle();
    for (int n = 0; n < 1500; n++) begin
      for (int p = 0; p < 2; p++)
        if ($urandom_range(3) == 0 && q[p].size() < 3)
          push(p, 1'($urandom_range(1)), 8'($urandom_range(15)), 8'($urandom));
      step(1'($urandom_range(99) == 0));
    end
    run_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
